video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter HSW, default 2: hsync width, in clocks.
REQ-002 Parameter HBP, default 1: horizontal back porch, in clocks.
REQ-003 Parameter HACT, default 10: active pixels per line.
REQ-004 Parameter HFP, default 2: horizontal front porch, in clocks.
REQ-005 Parameters VSW=1, VBP=1, VACT=4, VFP=1: vertical sync, back porch, active and front porch, in lines.
REQ-006 Local constants: HTOT=HSW+HBP+HACT+HFP (15); VTOT=VSW+VBP+VACT+VFP (7). Every parameter SHALL be at least 1.
REQ-007 Ports, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  advance enable.
- i_pattern_sel  in  2  test pattern select.
- o_vsync  out  1  vertical sync, active high.
- o_hsync  out  1  horizontal sync, active high.
- o_de  out  1  data enable.
- o_r_data, o_g_data, o_b_data  out  10 each  pixel data.
- o_frame_start  out  1  one-cycle pulse at frame origin.

Function
REQ-008 Counter h_cnt SHALL run 0..HTOT-1. Counter v_cnt SHALL run 0..VTOT-1. Both SHALL advance only on edges where i_en=1 and rst=0.
REQ-009 h_cnt SHALL wrap to 0 after HTOT-1. v_cnt SHALL increment on that wrap and SHALL wrap to 0 after VTOT-1.
REQ-010 Decode, from the current counter values:
- hsync = h_cnt<HSW.
- vsync = v_cnt<VSW.
- h_act = HSW+HBP <= h_cnt < HSW+HBP+HACT.
- v_act = VSW+VBP <= v_cnt < VSW+VBP+VACT.
- de = h_act & v_act.
REQ-011 All outputs SHALL be registered. Outputs SHALL reflect the decode of the counter values present before the edge, so outputs lag the counters by exactly 1 clock.
REQ-012 Coordinates: x = h_cnt-(HSW+HBP) and y = v_cnt-(VSW+VBP), both truncated to 10 bits.
REQ-013 Pattern data when de=1:
- sel 0: ramp, R=G=B=x.
- sel 1: checkerboard, R=G=B = (x[0]^y[0]) ? 10'h3FF : 10'h000.
- sel 2: R=frame_cnt, G=y, B=x.
- sel 3: R=G=B=10'h000.
REQ-014 R/G/B SHALL be 0 on every cycle where de=0.
REQ-015 Active pattern register: i_pattern_sel SHALL be sampled into it only on an enabled edge with h_cnt=0 and v_cnt=0. Mid-frame changes SHALL take effect at the next frame.
REQ-016 frame_cnt (10 bits) SHALL increment on the enabled edge where both counters wrap. It SHALL wrap 1023 -> 0.
REQ-017 o_frame_start SHALL be 1 for exactly one output cycle: the output cycle decoded from h_cnt=0, v_cnt=0.
REQ-018 Edges with i_en=0:
- Counters, frame_cnt and the active pattern SHALL hold.
- All outputs SHALL be driven 0 at that edge.
REQ-019 When i_en re-asserts, decode SHALL resume from the held counter values. No pixel SHALL be skipped or repeated.

Reset
REQ-020 On an edge with rst=1, h_cnt, v_cnt and frame_cnt SHALL be set to 0, regardless of i_en. This applies at any point, including mid-frame.
REQ-021 On an edge with rst=1, the active pattern SHALL be set to 0, and all outputs, including o_frame_start, SHALL be set to 0.
REQ-022 First enabled edge after rst falls: outputs = decode of (0,0). That gives o_hsync=1, o_vsync=1, o_frame_start=1, o_de=0 and zero data, and h_cnt becomes 1.

Verification
REQ-023 Reset release: rst=1 for 3 clocks with i_en=1 -> all outputs 0. First post-release output cycle -> hsync=1, vsync=1, frame_start=1.
REQ-024 Timing with defaults:
- o_hsync: high 2 of every 15 clocks.
- o_vsync: high for the first 15 clocks of every 105.
- o_de: high for 10 consecutive clocks, starting 3 clocks after the hsync rise, on output lines 2..5 only.
- Frame: 40 de cycles and one frame_start per 105 clocks.
REQ-025 Patterns:
- sel=1, first active line -> data 000,3FF,000,... over 10 pixels; second line -> 3FF,000,...
- sel=0 -> data 0..9 on each active line.
REQ-026 Pattern switch: i_pattern_sel changes 0->1 at output line 3 -> the remaining lines of that frame stay ramp; the next frame is checkerboard.
REQ-027 Enable gap: i_en=0 for 5 clocks at x=4 -> outputs 0 for those 5 cycles. After re-enable, data resumes at x=4, and that line still totals 10 de cycles with x=0..9 each exactly once.
REQ-028 Wrap and reset:
- sel=2 over 1025 frames -> R reads 0..1023 then 0.
- rst=1 asserted mid-line on active line 3 -> next enabled output cycle is the frame origin (frame_start=1, R=0 in the next active pixel).

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Video timing bundle: the enable and pattern select go into the generator;
// sync, data enable, pixel data and frame marker come out.
interface video_timing_gen_if;
  logic       en;
  logic [1:0] pattern_sel;
  logic       vsync;
  logic       hsync;
  logic       de;
  logic [9:0] r_data;
  logic [9:0] g_data;
  logic [9:0] b_data;
  logic       frame_start;

  modport master (
    input  en, pattern_sel,
    output vsync, hsync, de, r_data, g_data, b_data, frame_start
  );

  modport slave (
    output en, pattern_sel,
    input  vsync, hsync, de, r_data, g_data, b_data, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with test patterns: h/v counters, sync/active decode
// and a registered output stage that lags the counters by one clock.
module video_timing_gen #(
  parameter int HSW  = 2,
  parameter int HBP  = 1,
  parameter int HACT = 10,
  parameter int HFP  = 2,
  parameter int VSW  = 1,
  parameter int VBP  = 1,
  parameter int VACT = 4,
  parameter int VFP  = 1
) (
  input logic               clk,
  input logic               rst,
  video_timing_gen_if.master vid
);

  localparam int HTOT = HSW + HBP + HACT + HFP;
  localparam int VTOT = VSW + VBP + VACT + VFP;
  localparam int HCW  = (HTOT > 1) ? $clog2(HTOT) : 1;
  localparam int VCW  = (VTOT > 1) ? $clog2(VTOT) : 1;

  localparam logic [HCW-1:0] H_LAST     = HCW'(HTOT - 1);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(HSW);
  localparam logic [HCW-1:0] H_ACT_BEG  = HCW'(HSW + HBP);
  localparam logic [HCW-1:0] H_ACT_END  = HCW'(HSW + HBP + HACT);
  localparam logic [VCW-1:0] V_LAST     = VCW'(VTOT - 1);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(VSW);
  localparam logic [VCW-1:0] V_ACT_BEG  = VCW'(VSW + VBP);
  localparam logic [VCW-1:0] V_ACT_END  = VCW'(VSW + VBP + VACT);

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_COORD   = 2'd2,
    PAT_BLACK   = 2'd3
  } pattern_e;

  typedef struct packed {
    logic       vsync;
    logic       hsync;
    logic       de;
    logic       frame_start;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } pix_t;

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic [9:0]     frame_cnt;
  pattern_e       pattern;
  pix_t           pix_next;
  pix_t           pix_q;
  logic [9:0]     x;
  logic [9:0]     y;
  logic           h_act;
  logic           v_act;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    pix_next = '0;
    x        = 10'(h_cnt) - 10'(HSW + HBP);
    y        = 10'(v_cnt) - 10'(VSW + VBP);
    h_act    = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_act    = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);

    pix_next.hsync       = (h_cnt < H_SYNC_END);
    pix_next.vsync       = (v_cnt < V_SYNC_END);
    pix_next.de          = h_act && v_act;
    pix_next.frame_start = (h_cnt == '0) && (v_cnt == '0);

    if (pix_next.de) begin
      unique case (pattern)
        PAT_RAMP: begin
          pix_next.r = x;
          pix_next.g = x;
          pix_next.b = x;
        end
        PAT_CHECKER: begin
          pix_next.r = {10{x[0] ^ y[0]}};
          pix_next.g = {10{x[0] ^ y[0]}};
          pix_next.b = {10{x[0] ^ y[0]}};
        end
        PAT_COORD: begin
          pix_next.r = frame_cnt;
          pix_next.g = y;
          pix_next.b = x;
        end
        PAT_BLACK: begin
          pix_next.r = '0;
          pix_next.g = '0;
          pix_next.b = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which is what gives the fixed one-clock lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      pattern   <= PAT_RAMP;
      pix_q     <= '0;
    end else if (vid.en) begin
      pix_q <= pix_next;
      // Pattern changes only at the frame origin so a frame is never mixed.
      if (h_cnt == '0 && v_cnt == '0) begin
        pattern <= pattern_e'(vid.pattern_sel);
      end
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 10'd1;
        end else begin
          v_cnt <= v_cnt + VCW'(1);
        end
      end else begin
        h_cnt <= h_cnt + HCW'(1);
      end
    end else begin
      pix_q <= '0;
    end
  end

  assign vid.vsync       = pix_q.vsync;
  assign vid.hsync       = pix_q.hsync;
  assign vid.de          = pix_q.de;
  assign vid.frame_start = pix_q.frame_start;
  assign vid.r_data      = pix_q.r;
  assign vid.g_data      = pix_q.g;
  assign vid.b_data      = pix_q.b;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: stimulus pushes the expected output of each edge, a
// negedge monitor pops and compares; a small-raster instance covers frame wrap.
module tb_video_timing_gen;

  typedef struct packed {
    logic       vsync;
    logic       hsync;
    logic       de;
    logic       frame_start;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } obs_t;

  typedef struct packed {
    logic rst_cyc;
    obs_t o;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_w;

  video_timing_gen_if vif ();
  video_timing_gen_if wif ();

  video_timing_gen dut (
    .clk (clk),
    .rst (rst),
    .vid (vif)
  );

  video_timing_gen #(
    .HSW(1), .HBP(1), .HACT(1), .HFP(1),
    .VSW(1), .VBP(1), .VACT(1), .VFP(1)
  ) dut_wrap (
    .clk (clk),
    .rst (rst_w),
    .vid (wif)
  );

  int         checks = 0;
  int         errors = 0;
  entry_t     sb[$];
  int         n      = 0;
  logic [1:0] mpat   = 2'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference for the default 15x7 raster, written from the timing table.
  function automatic obs_t model(input int idx, input logic [1:0] pat);
    obs_t       o;
    int         h;
    int         v;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] f;
    logic [9:0] ck;
    h  = idx % 15;
    v  = (idx / 15) % 7;
    f  = 10'((idx / 105) % 1024);
    x  = 10'(h - 3);
    y  = 10'(v - 2);
    ck = (x[0] ^ y[0]) ? 10'h3FF : 10'h000;
    o             = '0;
    o.hsync       = (h < 2);
    o.vsync       = (v < 1);
    o.frame_start = (h == 0) && (v == 0);
    o.de          = (h >= 3) && (h < 13) && (v >= 2) && (v < 6);
    if (o.de) begin
      case (pat)
        2'd0: begin o.r = x;  o.g = x;  o.b = x;  end
        2'd1: begin o.r = ck; o.g = ck; o.b = ck; end
        2'd2: begin o.r = f;  o.g = y;  o.b = x;  end
        default: begin o.r = '0; o.g = '0; o.b = '0; end
      endcase
    end
    return o;
  endfunction

  task automatic step(input logic e, input logic [1:0] s, input logic r);
    entry_t ent;
    vif.en          = e;
    vif.pattern_sel = s;
    rst             = r;
    ent             = '0;
    ent.rst_cyc     = r;
    if (r) begin
      n    = 0;
      mpat = 2'd0;
    end else if (e) begin
      ent.o = model(n, mpat);
      if (n % 105 == 0) mpat = s;
      n++;
    end
    @(posedge clk);
    #1;
    sb.push_back(ent);
  endtask

  task automatic run(input int cycles, input logic e, input logic [1:0] s);
    repeat (cycles) step(e, s, 1'b0);
  endtask

  // Per-frame tallies, checked against hand counts whenever a frame_start arrives.
  int   de_n    = 0;
  int   hs_n    = 0;
  int   vs_n    = 0;
  bit   started = 0;
  entry_t cur;
  obs_t   act;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {vif.vsync, vif.hsync, vif.de, vif.frame_start,
             vif.r_data, vif.g_data, vif.b_data};
      check("pixel", 64'(act), 64'(cur.o));
      if (cur.rst_cyc) begin
        started = 0;
        de_n = 0; hs_n = 0; vs_n = 0;
      end else begin
        if (act.frame_start) begin
          if (started) begin
            check("frame_de_count",    64'(de_n), 64'd40);
            check("frame_hsync_count", 64'(hs_n), 64'd14);
            check("frame_vsync_count", 64'(vs_n), 64'd15);
          end
          started = 1;
          de_n = 0; hs_n = 0; vs_n = 0;
        end
        de_n += int'(act.de);
        hs_n += int'(act.hsync);
        vs_n += int'(act.vsync);
      end
    end
  end

  // Small raster: one active pixel per 16-clock frame, R carries frame_cnt.
  logic [9:0] exp_wr   = 10'd0;
  int         wrap_pix = 0;

  always @(negedge clk) begin
    if (wif.de) begin
      check("wrap_r", 64'(wif.r_data), 64'(exp_wr));
      exp_wr = exp_wr + 10'd1;
      wrap_pix++;
    end
  end

  initial begin
    rst             = 1'b1;
    rst_w           = 1'b1;
    vif.en          = 1'b1;
    vif.pattern_sel = 2'd0;
    wif.en          = 1'b1;
    wif.pattern_sel = 2'd2;

    fork
      begin
        repeat (3) step(1'b1, 2'd0, 1'b1);
        run(105, 1'b1, 2'd0);
        run(45, 1'b1, 2'd0);
        run(60, 1'b1, 2'd1);
        run(37, 1'b1, 2'd1);
        run(5, 1'b0, 2'd1);
        run(68, 1'b1, 2'd1);
        run(51, 1'b1, 2'd2);
        step(1'b1, 2'd2, 1'b1);
        run(210, 1'b1, 2'd2);
        run(105, 1'b1, 2'd3);
        run(2, 1'b1, 2'd3);
      end
      begin
        repeat (2) @(posedge clk);
        #1 rst_w = 1'b0;
        repeat (1025 * 16) @(posedge clk);
        #1 wif.en = 1'b0;
        repeat (2) @(negedge clk);
        check("wrap_pixel_count", 64'(wrap_pix), 64'd1025);
      end
    join

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
